// File: rtl/lp_pkg.sv
`default_nettype none
//==============================================================================
// lp_pkg - program-step encoding shared by the lp code-block models. Rev 1.0
//==============================================================================
package lp_pkg;

   localparam int STEP_W = 4;

   localparam logic [STEP_W-1:0] STEP_ENTRY  = 4'd0;
   localparam logic [STEP_W-1:0] STEP_INITX  = 4'd1;
   localparam logic [STEP_W-1:0] STEP_INITK  = 4'd2;
   localparam logic [STEP_W-1:0] STEP_TEST   = 4'd3;
   localparam logic [STEP_W-1:0] STEP_BRANCH = 4'd4;
   localparam logic [STEP_W-1:0] STEP_LOAD   = 4'd5;
   localparam logic [STEP_W-1:0] STEP_DOUBLE = 4'd6;
   localparam logic [STEP_W-1:0] STEP_INC    = 4'd7;
   localparam logic [STEP_W-1:0] STEP_OUT    = 4'd8;
   localparam logic [STEP_W-1:0] STEP_DONE   = 4'd9;
   localparam logic [STEP_W-1:0] STEP_PLOAD  = 4'd10;
   localparam logic [STEP_W-1:0] STEP_PINC   = 4'd11;
   localparam logic [STEP_W-1:0] STEP_POUT   = 4'd12;

endpackage
`default_nettype wire

// File: rtl/lp_codeblock.sv
`default_nettype none
//==============================================================================
// lp_codeblock - stuttering loop code block, source or loop-peeled program. Rev 1.0
//==============================================================================
module lp_codeblock
   import lp_pkg::*;
#(
   parameter int PEELED   = 0,
   parameter int ITER     = 3,
   parameter int DATA_W   = 4,
   parameter int SECRET_W = 2,
   parameter int K_W      = $clog2(ITER + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stutter_in,
   input  logic [SECRET_W-1:0] secret_in,
   output logic [K_W-1:0]      public_out,
   output logic                stutter,
   output logic                done,
   output logic [STEP_W-1:0]   step
);

   localparam int             MOD_W  = (DATA_W > K_W) ? DATA_W : K_W;
   localparam logic [K_W-1:0] ITER_K = K_W'(ITER);

   generate
      if (ITER < 1) begin : g_bad_iter
         $error("lp_codeblock: ITER must be at least 1");
      end
      if (SECRET_W > DATA_W) begin : g_bad_secret_w
         $error("lp_codeblock: SECRET_W must not exceed DATA_W");
      end
      if (ITER >= (1 << K_W)) begin : g_bad_k_w
         $error("lp_codeblock: K_W too narrow to hold ITER");
      end
   endgenerate

   logic [DATA_W-1:0] x;
   logic [K_W-1:0]    k;
   logic [DATA_W-1:0] secret_ext;
   logic [K_W-1:0]    mod_k;

   assign secret_ext = DATA_W'(secret_in);
   // k is at least 1 whenever mod_k is captured, so the divisor is never zero.
   assign mod_k      = K_W'(MOD_W'(x) % MOD_W'(k));
   assign done       = (step == STEP_DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         step       <= STEP_ENTRY;
         x          <= '0;
         k          <= '0;
         public_out <= '0;
         stutter    <= 1'b0;
      end else begin
         stutter <= stutter_in;
         if (!stutter_in) begin
            case (step)
               STEP_ENTRY:  step <= STEP_INITX;
               STEP_INITX: begin
                  x    <= '0;
                  step <= STEP_INITK;
               end
               STEP_INITK: begin
                  k    <= '0;
                  step <= (PEELED != 0) ? STEP_PLOAD : STEP_TEST;
               end
               STEP_TEST: begin
                  if (k < ITER_K) step <= (PEELED != 0) ? STEP_DOUBLE : STEP_BRANCH;
                  else            step <= STEP_DONE;
               end
               STEP_BRANCH: step <= (k == '0) ? STEP_LOAD : STEP_DOUBLE;
               STEP_LOAD: begin
                  x    <= secret_ext;
                  step <= STEP_INC;
               end
               STEP_DOUBLE: begin
                  x    <= x + x;
                  step <= STEP_INC;
               end
               STEP_INC: begin
                  k    <= k + 1'b1;
                  step <= STEP_OUT;
               end
               STEP_OUT: begin
                  public_out <= mod_k;
                  step       <= STEP_TEST;
               end
               STEP_DONE:   step <= STEP_DONE;
               STEP_PLOAD: begin
                  x    <= secret_ext;
                  step <= STEP_PINC;
               end
               STEP_PINC: begin
                  k    <= k + 1'b1;
                  step <= STEP_POUT;
               end
               STEP_POUT: begin
                  public_out <= mod_k;
                  step       <= STEP_TEST;
               end
               default:     step <= STEP_DONE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire
